// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//
// Soft clock-divider bank. It derives CHANNELS divided square waves and
// one-cycle strobes from a single reference clock. Each channel has a
// runtime divide ratio and phase offset, set through a register write port.
// The extlock flag drops on every reconfiguration or standby exit. It stays
// low through a relock interval, and then all channels restart phase-aligned.
//
// Ports
//   refclk     in   1            sole clock, rising edge
//   reset      in   1            synchronous, active-high
//   stdby      in   1            standby request, level-sensitive
//   cfg_we     in   1            configuration write strobe
//   cfg_ch     in   CH_W         target channel (>= CHANNELS is ignored)
//   cfg_div    in   DIV_W        divide ratio (clamped to >= 2)
//   cfg_phase  in   DIV_W        phase offset (clamped to div-1)
//   clk_out    out  CHANNELS     divided clocks, registered
//   stb        out  CHANNELS     one pulse per period, registered
//   extlock    out  1            all channels running current config
// ---------------------------------------------------------------------------
module clk_div_bank #(
   parameter int                          CHANNELS    = 3,
   parameter int                          DIV_W       = 8,
   parameter logic [CHANNELS*DIV_W-1:0]   DEFAULT_DIV = {8'd124, 8'd42, 8'd20},
   parameter int                          LOCK_CYCLES = 16,
   localparam int                         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  refclk,
   input  logic                  reset,
   input  logic                  stdby,
   input  logic                  cfg_we,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [DIV_W-1:0]      cfg_phase,
   output logic [CHANNELS-1:0]   clk_out,
   output logic [CHANNELS-1:0]   stb,
   output logic                  extlock
);

   localparam int                LC_W     = $clog2(LOCK_CYCLES + 1);
   localparam logic [LC_W-1:0]   LOCK_MAX = LC_W'(LOCK_CYCLES);
   localparam logic [DIV_W-1:0]  ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0]  TWO      = DIV_W'(2);
   localparam logic [CH_W:0]     CH_LIM   = (CH_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {
      ST_STBY,
      ST_WAIT,
      ST_LOCKED
   } state_t;

   // Divide ratio saturation: ratios below 2 cannot form a square wave.
   function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
      return (d < TWO) ? TWO : d;
   endfunction

   // Phase saturation against the already-clamped ratio.
   function automatic logic [DIV_W-1:0] sat_phase(input logic [DIV_W-1:0] p,
                                                  input logic [DIV_W-1:0] d);
      return (p >= d) ? (d - ONE) : p;
   endfunction

   state_t              state_q, state_d;
   logic [LC_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic                enter_lock;
   logic                run;
   logic                cfg_valid;
   logic [DIV_W-1:0]    wr_div, wr_phase;

   logic [DIV_W-1:0]    div_q   [CHANNELS];
   logic [DIV_W-1:0]    phase_q [CHANNELS];
   logic [DIV_W-1:0]    cnt_q   [CHANNELS];
   logic [DIV_W-1:0]    cnt_nxt [CHANNELS];
   logic [DIV_W-1:0]    half    [CHANNELS];

   assign cfg_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIM);
   assign wr_div    = sat_div(cfg_div);
   assign wr_phase  = sat_phase(cfg_phase, wr_div);

   // ---- configuration registers ----
   always_ff @(posedge refclk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            div_q[i]   <= DEFAULT_DIV[i*DIV_W +: DIV_W];
            phase_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_valid && (cfg_ch == CH_W'(i))) begin
               div_q[i]   <= wr_div;
               phase_q[i] <= wr_phase;
            end
         end
      end
   end

   // ---- lock FSM: state register ----
   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q    <= ST_WAIT;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // ---- lock FSM: next state ----
   // Standby wins the transition over a write; the write itself still lands
   // in the configuration registers above.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      enter_lock = 1'b0;
      case (state_q)
         ST_STBY: begin
            if (!stdby) begin
               state_d    = ST_WAIT;
               lock_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            if (stdby) begin
               state_d = ST_STBY;
            end else if (cfg_valid) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_MAX) begin
               state_d    = ST_LOCKED;
               enter_lock = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (stdby) begin
               state_d = ST_STBY;
            end else if (cfg_valid) begin
               state_d    = ST_WAIT;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_WAIT;
            lock_cnt_d = '0;
         end
      endcase
   end

   // Counters advance only while the bank stays locked across the edge.
   assign run = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         half[i]    = div_q[i] >> 1;
         cnt_nxt[i] = (cnt_q[i] == (div_q[i] - ONE)) ? '0 : (cnt_q[i] + ONE);
      end
   end

   // ---- channel counters ----
   // Every channel reloads its phase on the locking edge, so all channels
   // start aligned. Outside LOCKED the counters are simply held.
   always_ff @(posedge refclk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (enter_lock) begin
            cnt_q[i] <= phase_q[i];
         end else if (run) begin
            cnt_q[i] <= cnt_nxt[i];
         end
      end
   end

   // ---- registered outputs ----
   // Outputs are decoded from the count value being loaded on the same edge.
   // This keeps clk_out/stb aligned with cnt_q while staying registered.
   always_ff @(posedge refclk) begin
      if (reset) begin
         clk_out <= '0;
         stb     <= '0;
         extlock <= 1'b0;
      end else begin
         extlock <= (state_d == ST_LOCKED);
         for (int i = 0; i < CHANNELS; i++) begin
            if (enter_lock) begin
               clk_out[i] <= (phase_q[i] < half[i]);
               stb[i]     <= (phase_q[i] == '0);
            end else if (run) begin
               clk_out[i] <= (cnt_nxt[i] < half[i]);
               stb[i]     <= (cnt_nxt[i] == '0);
            end else begin
               clk_out[i] <= 1'b0;
               stb[i]     <= 1'b0;
            end
         end
      end
   end

endmodule
